// File: rtl/reg_file_if.sv
// Register-file access bus: one write port and two combinational read ports.
// The writeback stage and operand fetch drive the master side.
interface reg_file_if #(
    parameter int n = 32,
    parameter int r = 5
);
    logic         we;
    logic [r-1:0] wa;
    logic [n-1:0] wd;
    logic [r-1:0] ra1;
    logic [r-1:0] ra2;
    logic [n-1:0] rd1;
    logic [n-1:0] rd2;

    modport master (output we, wa, wd, ra1, ra2, input rd1, rd2);
    modport slave  (input we, wa, wd, ra1, ra2, output rd1, rd2);
endinterface

// File: rtl/reg_file.sv
// MIPS general-purpose register file: $0 reads zero, $sp resets to SP_INIT,
// with optional same-cycle write-to-read forwarding for the ALU operands.
module reg_file #(
    parameter int          n       = 32,
    parameter int          r       = 5,
    parameter logic [31:0] SP_INIT = 32'h0000_0FFC,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    reg_file_if.slave   bus
);
    localparam int NREGS  = 2 ** r;
    localparam int SP_IDX = 29;

    logic [n-1:0] regs_q [NREGS];
    logic [n-1:0] regs_d [NREGS];

    // NOTE: always_comb uses blocking assignments and starts from a full default, so no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (bus.we && (bus.wa != '0)) begin
            regs_d[bus.wa] = bus.wd;
        end
    end

    // NOTE: the array is deliberately reset here so $sp and every operand are defined after one reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? n'(SP_INIT) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    function automatic logic [n-1:0] read_port(input logic [r-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (BYPASS && bus.we && !reset && (bus.wa == addr)) begin
            return bus.wd;
        end else begin
            return regs_q[addr];
        end
    endfunction

    always_comb begin
        bus.rd1 = read_port(bus.ra1);
        bus.rd2 = read_port(bus.ra2);
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural general-purpose register file for the 32-bit MIPS CPU.
- Sits directly upstream of the ALU and drives its A and B operands through two read ports.
- Takes one writeback (ALU result or load data) per clock through a single write port.
- Register $0 is hard-wired to zero.
- $sp (register 29) resets to a configurable stack top.
- An optional write-first bypass lets a value written in cycle N be read by the ALU in the same cycle N.

Parameters:
- n, 32, data width in bits (matches ALU operand width)
- r, 5, register address width; register count is 2**r
- SP_INIT, 32'h0000_0FFC, reset value of register 29 ($sp)
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return stored contents only

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- we  input  1  write enable for write port
- wa  input  r  write address
- wd  input  n  write data
- ra1  input  r  read address, port 1 (feeds ALU A)
- ra2  input  r  read address, port 2 (feeds ALU B)
- rd1  output  n  read data, port 1
- rd2  output  n  read data, port 2

Behaviour:
- Storage: 2**r registers of n bits, updated only on rising edge of clk.
- Reset:
  - When reset=1 at a rising edge, every register clears to 0, except register 29, which loads SP_INIT.
  - Reset has priority over a simultaneous write; the write is discarded.
  - Reset asserted mid-stream takes effect at the next edge; no partial state is kept.
- Write:
  - When reset=0 and we=1 at a rising edge, register[wa] <= wd.
  - wa=0 is ignored; register 0 stays 0 permanently.
  - Only one write per cycle.
- Read:
  - Combinational, zero-cycle latency; rd1 and rd2 follow ra1 and ra2 within the same cycle.
  - rd1 = 0 whenever ra1=0; rd2 = 0 whenever ra2=0, regardless of we, wa or wd.
- Bypass (BYPASS=1):
  - If we=1, reset=0, wa!=0 and wa==ra1, then rd1 = wd in the same cycle; likewise for port 2.
  - Both ports may bypass simultaneously when ra1==ra2==wa.
  - With BYPASS=0, rd returns the pre-edge stored value; the new value is visible the cycle after the edge.
- Output values after reset:
  - Reads of any register return 0, except register 29, which returns SP_INIT.
  - No X is ever driven on rd1 or rd2 once one reset edge has occurred.
- Read-only use: both read ports may address the same register; both return identical data.
- Width rule: wd is stored unmodified, with no sign or zero extension; extension is the responsibility of upstream immediate logic.
- No internal state machine beyond the register array; there is no stall input, and the writer gates writes using we.

Test Plan:
- Reset, then read all 32 addresses on both ports -> 0 everywhere except ra=29, which returns 32'h0000_0FFC.
- we=1, wa=8, wd=32'hDEAD_BEEF, edge; next cycle ra1=8, ra2=8 -> rd1=rd2=32'hDEAD_BEEF.
- we=1, wa=0, wd=32'hFFFF_FFFF, edge; ra1=0 -> rd1=0, also in the write cycle with BYPASS=1.
- BYPASS=1: register 9 holds 5; in the same cycle drive we=1, wa=9, wd=7, ra1=9, ra2=9 -> rd1=rd2=7 before the edge. With BYPASS=0, the same stimulus gives 5 before the edge and 7 after.
- reset=1 and we=1, wa=10, wd=32'h1234 at the same edge -> register 10 reads 0 afterwards; register 29 reads SP_INIT.
- Write r1=3 and r2=4, then drive ra1=1, ra2=2 into the ALU with add select -> ALU output 7. Then write r1=32'hFFFF_FFFF and r2=1; add -> ALU output 0 (wrap-around), with operands delivered unmodified.
